// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: operand request and product/status bundle for seq_multiplier
interface seq_multiplier_if #(parameter int size = 64);
  logic start;
  logic is_signed;
  logic [size-1:0] a;
  logic [size-1:0] b;
  logic busy;
  logic done;
  logic [2*size-1:0] product;
  modport master(output start, is_signed, a, b, input busy, done, product);
  modport slave(input start, is_signed, a, b, output busy, done, product);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add signed/unsigned multiplier, one multiplier bit per cycle
module seq_multiplier #(parameter int size = 64) (
  input logic clk,
  input logic reset,
  seq_multiplier_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int cw = $clog2(size) + 1;
  state_t state, state_nx;
  logic [2*size-1:0] mcand, acc, acc_nx;
  logic [size-1:0] mplier, mag_a, mag_b;
  logic [cw-1:0] cnt;
  logic sign, last, accept;
  assign accept = state == IDLE && bus.start;
  assign last = cnt == cw'(size - 1);
  assign mag_a = bus.is_signed && bus.a[size-1] ? -bus.a : bus.a;
  assign mag_b = bus.is_signed && bus.b[size-1] ? -bus.b : bus.b;
  assign acc_nx = mplier[0] ? acc + mcand : acc;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) : state == RUN ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // the multiplicand is kept pre-shifted so each iteration adds it without a barrel shifter
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
      sign <= 1'b0;
      bus.product <= '0;
    end else if (accept) begin
      mcand <= {{size{1'b0}}, mag_a};
      mplier <= mag_b;
      acc <= '0;
      cnt <= '0;
      sign <= (bus.a[size-1] ^ bus.b[size-1]) & bus.is_signed;
    end else if (state == RUN) begin
      acc <= acc_nx;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      if (last) bus.product <= sign ? -acc_nx : acc_nx;
    end
endmodule
